multi_cycle_control: RTL and testbench

Multi-cycle control unit: the sequencer that drives the ALU's `ALUOp` and `ALUSrcB` inputs and consumes its `zero` flag. It replaces the single-cycle combinational decoder.
- Latches the 6-bit opcode, steps each instruction through IF/ID/EXE/MEM/WB states, and issues every datapath strobe per state.
- Counts retired instructions.
- Sits between instruction memory/IR and the datapath (PC, register file, ALU, data memory).

---
 rtl/multi_cycle_control.sv | 158 +++++++++++++++
 tb/tb_multi_cycle_control.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_control.sv
// Multi-cycle control sequencer: steps each instruction through IF/ID/EXE/MEM/WB,
// decodes datapath strobes from the state register and the latched opcode, and counts retirements.
module multi_cycle_control (
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  Opcode,
  input  logic        Zero,
  output logic        PCWre,
  output logic [1:0]  PCSrc,
  output logic        InsMemRW,
  output logic        IRWre,
  output logic        ExtSel,
  output logic        ALUSrcB,
  output logic [2:0]  ALUOp,
  output logic        mRD,
  output logic        mWR,
  output logic        RegWre,
  output logic        RegDst,
  output logic        DBDataSrc,
  output logic [2:0]  State,
  output logic        Halted,
  output logic [15:0] RetireCount
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CNT_W = 16;

  localparam logic [OP_W-1:0] OP_ADD  = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB  = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b000010;
  localparam logic [OP_W-1:0] OP_OR   = 6'b010000;
  localparam logic [OP_W-1:0] OP_AND  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI  = 6'b010010;
  localparam logic [OP_W-1:0] OP_XOR  = 6'b010011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW   = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110100;
  localparam logic [OP_W-1:0] OP_J    = 6'b111000;
  localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] retire_q;

  logic       is_al, is_rtype, is_lw, is_sw, is_beq, is_j, is_halt;
  logic       dec_src_b, dec_ext;
  logic [2:0] dec_alu_op;
  logic       in_exec;

  // Opcode classification of the latched instruction
  always_comb begin
    is_al      = 1'b0;
    is_rtype   = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_beq     = 1'b0;
    is_j       = 1'b0;
    is_halt    = 1'b0;
    dec_src_b  = 1'b0;
    dec_ext    = 1'b0;
    dec_alu_op = 3'b000;
    case (op_q)
      OP_ADD:  begin is_al = 1'b1; is_rtype = 1'b1; dec_alu_op = 3'b000; end
      OP_SUB:  begin is_al = 1'b1; is_rtype = 1'b1; dec_alu_op = 3'b001; end
      OP_ADDI: begin is_al = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b1; dec_alu_op = 3'b000; end
      OP_OR:   begin is_al = 1'b1; is_rtype = 1'b1; dec_alu_op = 3'b011; end
      OP_AND:  begin is_al = 1'b1; is_rtype = 1'b1; dec_alu_op = 3'b100; end
      OP_ORI:  begin is_al = 1'b1; dec_src_b = 1'b1; dec_alu_op = 3'b011; end
      OP_XOR:  begin is_al = 1'b1; is_rtype = 1'b1; dec_alu_op = 3'b110; end
      OP_SW:   begin is_sw = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b1; end
      OP_LW:   begin is_lw = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b1; end
      OP_BEQ:  begin is_beq = 1'b1; dec_alu_op = 3'b001; end
      OP_J:    is_j = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  // Next-state logic; halt parks in the ID encoding with the halted flag set
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (state_q)
        S_IF:     state_d = S_ID;
        S_ID: begin
          if (is_halt)           halted_d = 1'b1;
          else if (is_al)        state_d  = S_EXE_AL;
          else if (is_beq)       state_d  = S_EXE_BR;
          else if (is_lw | is_sw) state_d = S_EXE_LS;
          else                   state_d  = S_IF;
        end
        S_EXE_AL: state_d = S_WB_AL;
        S_WB_AL:  state_d = S_IF;
        S_EXE_BR: state_d = S_IF;
        S_EXE_LS: state_d = S_MEM;
        S_MEM:    state_d = is_lw ? S_WB_LD : S_IF;
        S_WB_LD:  state_d = S_IF;
        default:  state_d = S_IF;
      endcase
    end
  end

  assign in_exec = (state_q != S_IF) && (state_q != S_ID);

  // Datapath strobes decoded from state and latched opcode
  always_comb begin
    InsMemRW  = (state_q == S_IF);
    IRWre     = (state_q == S_IF);
    ExtSel    = (state_q != S_IF) && dec_ext;
    ALUSrcB   = in_exec && dec_src_b;
    ALUOp     = in_exec ? dec_alu_op : 3'b000;
    mRD       = (state_q == S_MEM) && is_lw;
    mWR       = (state_q == S_MEM) && is_sw;
    RegWre    = (state_q == S_WB_AL) || (state_q == S_WB_LD);
    RegDst    = (state_q == S_WB_AL) && is_rtype;
    DBDataSrc = (state_q == S_WB_LD);
    PCWre     = (state_d == S_IF);
    PCSrc     = 2'b00;
    if (PCWre) begin
      if ((state_q == S_ID) && is_j)       PCSrc = 2'b11;
      else if ((state_q == S_EXE_BR) && Zero) PCSrc = 2'b01;
    end
  end

  assign State       = state_q;
  assign Halted      = halted_q;
  assign RetireCount = retire_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IF;
      op_q     <= '0;
      halted_q <= 1'b0;
      retire_q <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      if (state_q == S_IF) op_q <= Opcode;
      if (PCWre && (retire_q != CNT_MAX)) retire_q <= retire_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench: each instruction pushes its expected per-cycle output vectors,
// which are popped and compared mid-cycle against the sequencer outputs.
module tb_multi_cycle_control;

  logic        CLK = 1'b0;
  logic        RST;
  logic [5:0]  Opcode;
  logic        Zero;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic        InsMemRW, IRWre, ExtSel, ALUSrcB;
  logic [2:0]  ALUOp;
  logic        mRD, mWR, RegWre, RegDst, DBDataSrc;
  logic [2:0]  State;
  logic        Halted;
  logic [15:0] RetireCount;

  typedef struct packed {
    logic [2:0]  st;
    logic        pcwre;
    logic [1:0]  pcsrc;
    logic        insmem;
    logic        irwre;
    logic        ext;
    logic        srcb;
    logic [2:0]  aluop;
    logic        mrd;
    logic        mwr;
    logic        regwre;
    logic        regdst;
    logic        dbsrc;
    logic        halted;
    logic [15:0] retire;
  } vec_t;

  vec_t  obs;
  vec_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [15:0] m_ret = 16'd0;

  multi_cycle_control dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Zero(Zero),
    .PCWre(PCWre), .PCSrc(PCSrc), .InsMemRW(InsMemRW), .IRWre(IRWre),
    .ExtSel(ExtSel), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
    .RegWre(RegWre), .RegDst(RegDst), .DBDataSrc(DBDataSrc), .State(State),
    .Halted(Halted), .RetireCount(RetireCount)
  );

  always #5 CLK = ~CLK;

  assign obs = {State, PCWre, PCSrc, InsMemRW, IRWre, ExtSel, ALUSrcB, ALUOp,
                mRD, mWR, RegWre, RegDst, DBDataSrc, Halted, RetireCount};

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input vec_t got, input vec_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t if_vec();
    vec_t v = '0;
    v.st = 3'b000; v.insmem = 1'b1; v.irwre = 1'b1; v.retire = m_ret;
    return v;
  endfunction

  function automatic void retire_one();
    if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
  endfunction

  // Reference expectations for one instruction, one vector per cycle
  task automatic push_instr(input logic [5:0] op, input logic z);
    vec_t v;
    int   kind;   // 0 nop, 1 alu, 2 beq, 3 lw, 4 sw, 5 j, 6 halt
    logic rt, sb, ex;
    logic [2:0] ao;
    rt = 0; sb = 0; ex = 0; ao = 3'b000; kind = 0;
    case (op)
      6'b000000: begin kind = 1; rt = 1; ao = 3'b000; end
      6'b000001: begin kind = 1; rt = 1; ao = 3'b001; end
      6'b000010: begin kind = 1; sb = 1; ex = 1; ao = 3'b000; end
      6'b010000: begin kind = 1; rt = 1; ao = 3'b011; end
      6'b010001: begin kind = 1; rt = 1; ao = 3'b100; end
      6'b010010: begin kind = 1; sb = 1; ex = 0; ao = 3'b011; end
      6'b010011: begin kind = 1; rt = 1; ao = 3'b110; end
      6'b110000: begin kind = 4; sb = 1; ex = 1; end
      6'b110001: begin kind = 3; sb = 1; ex = 1; end
      6'b110100: begin kind = 2; ao = 3'b001; end
      6'b111000: kind = 5;
      6'b111111: kind = 6;
      default:   kind = 0;
    endcase
    exp_q.push_back(if_vec());
    v = '0; v.st = 3'b001; v.ext = ex; v.retire = m_ret;
    if (kind == 0 || kind == 5) begin
      v.pcwre = 1; v.pcsrc = (kind == 5) ? 2'b11 : 2'b00;
      exp_q.push_back(v); retire_one();
    end else if (kind == 6) begin
      exp_q.push_back(v);
      for (int i = 0; i < 20; i++) begin
        v = '0; v.st = 3'b001; v.halted = 1; v.retire = m_ret;
        exp_q.push_back(v);
      end
    end else begin
      exp_q.push_back(v);
      v = '0; v.ext = ex; v.srcb = sb; v.aluop = ao; v.retire = m_ret;
      if (kind == 1) begin
        v.st = 3'b110; exp_q.push_back(v);
        v.st = 3'b111; v.regwre = 1; v.regdst = rt; v.pcwre = 1;
        exp_q.push_back(v); retire_one();
      end else if (kind == 2) begin
        v.st = 3'b101; v.pcwre = 1; v.pcsrc = z ? 2'b01 : 2'b00;
        exp_q.push_back(v); retire_one();
      end else begin
        v.st = 3'b010; exp_q.push_back(v);
        v.st = 3'b011;
        if (kind == 4) begin
          v.mwr = 1; v.pcwre = 1; exp_q.push_back(v); retire_one();
        end else begin
          v.mrd = 1; exp_q.push_back(v);
          v.st = 3'b100; v.mrd = 0; v.regwre = 1; v.dbsrc = 1; v.pcwre = 1;
          exp_q.push_back(v); retire_one();
        end
      end
    end
  endtask

  task automatic do_cycle(input string tag);
    vec_t e;
    @(negedge CLK);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s got=cycle exp=empty_queue", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  // Called one time unit after the edge that starts the IF cycle
  task automatic run_instr(input string tag, input logic [5:0] op, input logic z, input logic is_br);
    push_instr(op, z);
    Opcode = op;
    Zero   = is_br ? z : 1'($urandom);
    do_cycle(tag);
    advance();
    while (exp_q.size() > 0) begin
      Opcode = 6'($urandom);
      if (!is_br) Zero = 1'($urandom);
      do_cycle(tag);
      advance();
    end
  endtask

  initial begin
    RST = 1'b0; Opcode = 6'b000000; Zero = 1'b0;
    #2;
    check("reset_state", obs, if_vec());
    advance();
    RST = 1'b1;

    run_instr("addi", 6'b000010, 1'b0, 1'b0);
    run_instr("lw",   6'b110001, 1'b0, 1'b0);
    run_instr("sw",   6'b110000, 1'b0, 1'b0);
    run_instr("beq_z1", 6'b110100, 1'b1, 1'b1);
    run_instr("beq_z0", 6'b110100, 1'b0, 1'b1);
    run_instr("j",    6'b111000, 1'b0, 1'b0);
    run_instr("nop",  6'b101010, 1'b0, 1'b0);
    run_instr("add",  6'b000000, 1'b0, 1'b0);
    run_instr("sub",  6'b000001, 1'b0, 1'b0);
    run_instr("or",   6'b010000, 1'b0, 1'b0);
    run_instr("and",  6'b010001, 1'b0, 1'b0);
    run_instr("ori",  6'b010010, 1'b0, 1'b0);
    run_instr("xor",  6'b010011, 1'b0, 1'b0);

    // Reset asserted mid-instruction while sw is in MEM
    push_instr(6'b110000, 1'b0);
    Opcode = 6'b110000;
    for (int i = 0; i < 4; i++) begin
      do_cycle("sw_pre_rst");
      if (i < 3) begin
        advance();
        Opcode = 6'($urandom);
      end
    end
    #1 RST = 1'b0;
    m_ret = 16'd0;
    #1 check("rst_in_mem", obs, if_vec());
    advance();
    RST = 1'b1;
    run_instr("post_rst_addi", 6'b000010, 1'b0, 1'b0);

    // Saturation: preload the counter to its ceiling, then retire more work
    force dut.retire_q = 16'hFFFF;
    #1 release dut.retire_q;
    m_ret = 16'hFFFF;
    run_instr("sat_add", 6'b000000, 1'b0, 1'b0);
    run_instr("sat_j",   6'b111000, 1'b0, 1'b0);

    run_instr("halt", 6'b111111, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
